st_pkt_gen: RTL and testbench

Avalon-ST packet generator: on a start pulse it emits a programmed number of packets of programmed byte length onto an `avln_st` source port, honouring `ready` backpressure, with a programmable idle gap between packets. Payload words carry packet and word indices so a downstream sink can check them. It sits upstream of the stream buffering/delay blocks as a traffic source for bring-up and loopback testing.

---
 rtl/st_pkt_gen_if.sv | 27 ++
 rtl/st_pkt_gen.sv | 186 ++++++++++++++++++
 tb/tb_st_pkt_gen.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/st_pkt_gen_if.sv
// Avalon-ST packet stream bundle: 64-bit data with sop/eop/empty framing and valid/ready handshake.
interface st_pkt_gen_if;
  logic [63:0] data;
  logic        sop;
  logic        eop;
  logic [2:0]  empty;
  logic        valid;
  logic        ready;

  modport master (
    output data,
    output sop,
    output eop,
    output empty,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  sop,
    input  eop,
    input  empty,
    input  valid,
    output ready
  );
endinterface

// File: rtl/st_pkt_gen.sv
// Avalon-ST traffic source: emits a programmed run of indexed packets with optional idle gaps,
// honouring ready backpressure. Every output comes straight from a register.
module st_pkt_gen #(
  parameter int BYTES_PER_WORD = 8
) (
  input  logic                sys_clk_i,
  input  logic                reset_n_i,
  input  logic                start_i,
  input  logic [15:0]         pkt_len_i,
  input  logic [15:0]         pkt_count_i,
  input  logic [7:0]          gap_i,
  st_pkt_gen_if.master        out_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [15:0]         pkts_sent_o
);

  localparam int WSHIFT = $clog2(BYTES_PER_WORD);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP,
    S_DONE
  } state_e;

  state_e      state_q;
  logic [15:0] cnt_q;
  logic [7:0]  gap_q;
  logic [7:0]  gap_cnt_q;
  logic [12:0] last_word_q;
  logic [2:0]  empty_last_q;
  logic [15:0] pkt_idx_q;
  logic [12:0] word_idx_q;
  logic [15:0] pkts_sent_q;

  logic        valid_q;
  logic        sop_q;
  logic        eop_q;
  logic [2:0]  empty_q;
  logic [63:0] data_q;
  logic        busy_q;
  logic        done_q;

  // Length is taken as max(len,1); working from len-1 gives the last word index and
  // the eop empty count directly, without a 17-bit round-up.
  logic [15:0] len_m1_d;
  logic [12:0] last_word_d;
  logic [2:0]  empty_last_d;
  logic [12:0] word_nxt_d;
  logic [15:0] pkt_nxt_d;
  logic        last_pkt_d;

  assign len_m1_d     = (pkt_len_i == 16'd0) ? 16'd0 : pkt_len_i - 16'd1;
  assign last_word_d  = 13'(len_m1_d >> WSHIFT);
  assign empty_last_d = 3'(BYTES_PER_WORD - 1) - len_m1_d[2:0];
  assign word_nxt_d   = word_idx_q + 13'd1;
  assign pkt_nxt_d    = pkt_idx_q + 16'd1;
  assign last_pkt_d   = (pkt_idx_q == cnt_q - 16'd1);

  function automatic logic [63:0] mk_data(input logic [15:0] p, input logic [12:0] k);
    return {16'h0, p, 16'h0, 3'b000, k};
  endfunction

  always_ff @(posedge sys_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      gap_q        <= '0;
      gap_cnt_q    <= '0;
      last_word_q  <= '0;
      empty_last_q <= '0;
      pkt_idx_q    <= '0;
      word_idx_q   <= '0;
      pkts_sent_q  <= '0;
      valid_q      <= 1'b0;
      sop_q        <= 1'b0;
      eop_q        <= 1'b0;
      empty_q      <= '0;
      data_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            cnt_q        <= pkt_count_i;
            gap_q        <= gap_i;
            last_word_q  <= last_word_d;
            empty_last_q <= empty_last_d;
            pkts_sent_q  <= '0;
            pkt_idx_q    <= '0;
            word_idx_q   <= '0;
            if (pkt_count_i != 16'd0) begin
              state_q <= S_SEND;
              busy_q  <= 1'b1;
              valid_q <= 1'b1;
              sop_q   <= 1'b1;
              eop_q   <= (last_word_d == 13'd0);
              empty_q <= (last_word_d == 13'd0) ? empty_last_d : 3'd0;
              data_q  <= mk_data(16'd0, 13'd0);
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end

        S_SEND: begin
          if (out_o.ready) begin
            if (eop_q) begin
              pkts_sent_q <= pkts_sent_q + 16'd1;
              if (last_pkt_d) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                valid_q <= 1'b0;
                sop_q   <= 1'b0;
                eop_q   <= 1'b0;
                empty_q <= '0;
                data_q  <= '0;
              end else begin
                pkt_idx_q  <= pkt_nxt_d;
                word_idx_q <= '0;
                if (gap_q == 8'd0) begin
                  // Back-to-back: next packet's sop follows the eop directly.
                  sop_q   <= 1'b1;
                  eop_q   <= (last_word_q == 13'd0);
                  empty_q <= (last_word_q == 13'd0) ? empty_last_q : 3'd0;
                  data_q  <= mk_data(pkt_nxt_d, 13'd0);
                end else begin
                  state_q   <= S_GAP;
                  gap_cnt_q <= gap_q;
                  valid_q   <= 1'b0;
                  sop_q     <= 1'b0;
                  eop_q     <= 1'b0;
                  empty_q   <= '0;
                  data_q    <= '0;
                end
              end
            end else begin
              word_idx_q <= word_nxt_d;
              sop_q      <= 1'b0;
              eop_q      <= (word_nxt_d == last_word_q);
              empty_q    <= (word_nxt_d == last_word_q) ? empty_last_q : 3'd0;
              data_q     <= mk_data(pkt_idx_q, word_nxt_d);
            end
          end
        end

        S_GAP: begin
          // The sop word is loaded on the last idle cycle so it is valid right after the gap.
          if (gap_cnt_q == 8'd1) begin
            state_q <= S_SEND;
            valid_q <= 1'b1;
            sop_q   <= 1'b1;
            eop_q   <= (last_word_q == 13'd0);
            empty_q <= (last_word_q == 13'd0) ? empty_last_q : 3'd0;
            data_q  <= mk_data(pkt_idx_q, 13'd0);
          end else begin
            gap_cnt_q <= gap_cnt_q - 8'd1;
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign out_o.valid = valid_q;
  assign out_o.data  = data_q;
  assign out_o.sop   = sop_q;
  assign out_o.eop   = eop_q;
  assign out_o.empty = empty_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pkts_sent_o = pkts_sent_q;

endmodule

// File: tb/tb_st_pkt_gen.sv
// Randomized bench for st_pkt_gen: a queue of expected words built from the packet rules
// is compared cycle by cycle against the stream, along with gap, busy, done and count timing.
module tb_st_pkt_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] pkt_len;
  logic [15:0] pkt_count;
  logic [7:0]  gap;
  logic        busy;
  logic        done;
  logic [15:0] pkts_sent;

  int n_chk  = 0;
  int n_fail = 0;

  logic [68:0] exp_q[$];

  st_pkt_gen_if bus ();

  st_pkt_gen dut (
    .sys_clk_i   (clk),
    .reset_n_i   (rst_n),
    .start_i     (start),
    .pkt_len_i   (pkt_len),
    .pkt_count_i (pkt_count),
    .gap_i       (gap),
    .out_o       (bus),
    .busy_o      (busy),
    .done_o      (done),
    .pkts_sent_o (pkts_sent)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  function automatic logic [68:0] obs();
    return {bus.sop, bus.eop, bus.empty, bus.data};
  endfunction

  task automatic chk(input string tag, input logic [68:0] got, input logic [68:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_word"},  obs(), 69'd0);
    chk({tag, "_valid"}, 69'(bus.valid), 69'd0);
    chk({tag, "_busy"},  69'(busy), 69'd0);
    chk({tag, "_done"},  69'(done), 69'd0);
    chk({tag, "_sent"},  69'(pkts_sent), 69'd0);
  endtask

  // rmode: 0 = ready always high, 1 = ready pattern 1,0,0,1, 2 = random ready.
  // inj: run cycle at which a conflicting start is pulsed (-1 = none).
  task automatic run(input int len, input int cnt, input int g, input int rmode, input int inj);
    int          lenf, nw, emp, sent, gl, cyc, limit;
    logic [68:0] w;
    logic [2:0]  e3;
    logic [15:0] p16, k16;
    logic [3:0]  rpat;
    rpat  = 4'b1001;
    lenf  = (len == 0) ? 1 : len;
    nw    = (lenf + 7) / 8;
    emp   = (8 - (lenf % 8)) % 8;
    exp_q.delete();
    for (int p = 0; p < cnt; p++) begin
      for (int k = 0; k < nw; k++) begin
        p16 = 16'(p);
        k16 = 16'(k);
        e3  = (k == nw - 1) ? 3'(emp) : 3'd0;
        w   = {(k == 0), (k == nw - 1), e3, 16'h0, p16, 16'h0, k16};
        exp_q.push_back(w);
      end
    end
    limit = cnt * (nw * 4 + g + 4) + 20;

    @(negedge clk);
    pkt_len   = 16'(len);
    pkt_count = 16'(cnt);
    gap       = 8'(g);
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;

    sent = 0;
    gl   = 0;
    cyc  = 0;
    while (exp_q.size() > 0 && cyc < limit) begin
      start = 1'b0;
      chk("valid", 69'(bus.valid), 69'(gl == 0));
      chk("busy",  69'(busy), 69'd1);
      chk("done",  69'(done), 69'd0);
      chk("pkts_sent", 69'(pkts_sent), 69'(sent));
      if (cyc == inj) begin
        start     = 1'b1;
        pkt_len   = 16'd8;
        pkt_count = 16'd7;
        gap       = 8'd5;
      end
      case (rmode)
        0:       bus.ready = 1'b1;
        1:       bus.ready = rpat[cyc % 4];
        default: bus.ready = 1'($urandom_range(0, 1));
      endcase
      if (bus.valid) chk("word", obs(), exp_q[0]);
      if (gl > 0) begin
        gl--;
      end else if (bus.valid && bus.ready) begin
        w = exp_q.pop_front();
        if (w[67]) begin
          sent++;
          if (exp_q.size() > 0) gl = g;
        end
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (exp_q.size() > 0) chk("timeout_words_left", 69'(exp_q.size()), 69'd0);

    chk("end_done",  69'(done), 69'd1);
    chk("end_busy",  69'(busy), 69'd0);
    chk("end_valid", 69'(bus.valid), 69'd0);
    chk("end_sent",  69'(pkts_sent), 69'(cnt));

    // A start during the done cycle must be ignored.
    start     = 1'b1;
    pkt_len   = 16'd8;
    pkt_count = 16'd3;
    gap       = 8'd0;
    @(negedge clk);
    start = 1'b0;
    chk("ign_done",  69'(done), 69'd0);
    chk("ign_busy",  69'(busy), 69'd0);
    chk("ign_valid", 69'(bus.valid), 69'd0);
    bus.ready = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    pkt_len   = '0;
    pkt_count = '0;
    gap       = '0;
    bus.ready = 1'b0;
    #1;
    all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    bus.ready = 1'b1;
    @(negedge clk);
    all_zero("idle");

    run(20, 2, 0, 0, -1);
    run(64, 1, 0, 1, -1);
    run(1, 3, 2, 0, -1);
    run(0, 0, 0, 0, -1);
    run(0, 2, 1, 2, -1);
    run(65535, 1, 0, 0, -1);
    run(40, 3, 1, 2, 4);
    run(9, 4, 0, 1, 2);

    for (int i = 0; i < 8; i++) begin
      run(int'($urandom_range(0, 100)), int'($urandom_range(0, 4)),
          int'($urandom_range(0, 3)), 2, int'($urandom_range(0, 10)));
    end

    // Reset while the third word (p1 k0) is stalled by ready=0.
    @(negedge clk);
    pkt_len   = 16'd16;
    pkt_count = 16'd3;
    gap       = 8'd0;
    bus.ready = 1'b1;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.ready = 1'b0;
    chk("rst_pre_word",  obs(), {1'b1, 1'b0, 3'd0, 16'h0, 16'd1, 16'h0, 16'd0});
    chk("rst_pre_valid", 69'(bus.valid), 69'd1);
    chk("rst_pre_sent",  69'(pkts_sent), 69'd1);
    #2 rst_n = 1'b0;
    #1 all_zero("rst_mid");
    @(negedge clk);
    all_zero("rst_hold");
    rst_n     = 1'b1;
    bus.ready = 1'b1;
    @(negedge clk);
    all_zero("rst_release");
    run(16, 3, 0, 0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
